// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, start/data/parity/stop sampling on an
// oversampled clock. Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 2,
  parameter int STOP_WIDTH = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  rx_clk,
  input  logic                  rst,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int              CW        = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]   CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam bit              PAR_EN    = (PARITY == 1) || (PARITY == 2);
  localparam logic [3:0]      IDX_LAST  = 4'(DATA_WIDTH - 1);
  localparam logic [1:0]      STOP_LAST = 2'(STOP_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic par_bit(input logic [DATA_WIDTH-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  logic                  sync_q, rx_s_q, prev_q;
  logic                  fall_d, samp_d;
  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [3:0]            idx_q;
  logic [1:0]            stop_q;
  logic                  par_flag_q, frm_flag_q;
  logic [DATA_WIDTH-1:0] shreg_q, data_q;
  logic                  valid_q, perr_q, ferr_q;

  // Synchroniser and edge-history stage
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= rx_in;
      rx_s_q <= sync_q;
      prev_q <= rx_s_q;
    end
  end

  assign fall_d = prev_q & ~rx_s_q;

`ifdef UART_RX_MAJORITY_EN
  // rx_s_q, prev_q and hist_q form the 3-deep history voted on at each sample
  logic hist_q;
  always_ff @(posedge rx_clk) begin
    if (rst) hist_q <= 1'b1;
    else     hist_q <= prev_q;
  end
  assign samp_d = maj3(rx_s_q, prev_q, hist_q);
`else
  assign samp_d = rx_s_q;
`endif

  // Frame FSM and registered output stage
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_q     <= '0;
      par_flag_q <= 1'b0;
      frm_flag_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (fall_d) begin
            state_q    <= S_START;
            par_flag_q <= 1'b0;
            frm_flag_q <= 1'b0;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= samp_d ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            for (int i = 0; i < DATA_WIDTH; i++) begin
              if (idx_q == 4'(i)) shreg_q[i] <= samp_d;
            end
            if (idx_q == IDX_LAST) begin
              stop_q  <= '0;
              state_q <= PAR_EN ? S_PARITY : S_STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (samp_d != par_bit(shreg_q)) par_flag_q <= 1'b1;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (!samp_d) frm_flag_q <= 1'b1;
            // Leaving mid-stop-bit lets an immediately following start bit be seen
            if (stop_q == STOP_LAST) begin
              data_q  <= shreg_q;
              valid_q <= 1'b1;
              perr_q  <= par_flag_q;
              ferr_q  <= frm_flag_q | ~samp_d;
              state_q <= S_IDLE;
            end else begin
              stop_q <= stop_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames checked
// against a frame-level model (word, parity rule, stop bits, latency).
module tb_uart_rx;

  localparam int OS  = 16;
  localparam int NB  = 8;
  // rx_in low at cycle P -> rx_s low at P+2, start sample +OS/2, 10 more bit samples, valid +1
  localparam int LAT = 2 + OS / 2 + (NB + 1 + 1) * OS + 1;

  logic       rx_clk;
  logic       rst;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int         c;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } pulse_t;
  pulse_t pq[$];

  uart_rx #(.DATA_WIDTH(NB), .PARITY(2), .STOP_WIDTH(1), .OVERSAMPLE(OS)) dut (
    .rx_clk    (rx_clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  initial begin
    rx_clk = 1'b0;
    forever #5 rx_clk = ~rx_clk;
  end

  always @(posedge rx_clk) cyc <= cyc + 1;

  always @(negedge rx_clk) begin
    if (data_valid === 1'b1)
      pq.push_back('{c: cyc, d: data_out, pe: parity_err, fe: frame_err});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    rx_in = b;
    repeat (n) @(posedge rx_clk);
    #1;
  endtask

  // One frame; glitch_k flips one cycle at the centre of data bit k,
  // rst_k pulses reset for one cycle in the middle of data bit k.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                            input int glitch_k, input int rst_k, output int p0);
    p0 = cyc;
    hold(1'b0, OS);
    for (int k = 0; k < NB; k++) begin
      if (k == glitch_k) begin
        hold(d[k], OS / 2);
        hold(~d[k], 1);
        hold(d[k], OS / 2 - 1);
      end else if (k == rst_k) begin
        hold(d[k], OS / 2);
        rst = 1'b1;
        hold(d[k], 1);
        rst = 1'b0;
        hold(d[k], OS / 2 - 1);
      end else begin
        hold(d[k], OS);
      end
    end
    hold(pbit, OS);
    hold(sbit, OS);
  endtask

  task automatic expect_word(input string tag, input int p0, input logic [7:0] d,
                             input logic pe, input logic fe);
    pulse_t p;
    check({tag, "_pulse"}, 32'(pq.size() != 0), 32'd1);
    if (pq.size() != 0) begin
      p = pq.pop_front();
      check({tag, "_lat"},  32'(p.c - p0), 32'(LAT));
      check({tag, "_data"}, 32'(p.d), 32'(d));
      check({tag, "_perr"}, 32'(p.pe), 32'(pe));
      check({tag, "_ferr"}, 32'(p.fe), 32'(fe));
    end
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, "_nopulse"}, 32'(pq.size()), 32'd0);
    pq.delete();
  endtask

  initial begin
    int         p0, p1;
    logic [7:0] d, gw;
    logic       pbit, sbit;

    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(posedge rx_clk);
    #1;
    check("rst_data",  32'(data_out),   32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_perr",  32'(parity_err), 32'd0);
    check("rst_ferr",  32'(frame_err),  32'd0);
    rst = 1'b0;
    hold(1'b1, 2 * OS);
    expect_quiet("idle");

    send_frame(8'hA5, 1'b0, 1'b1, -1, -1, p0);
    hold(1'b1, OS);
    expect_word("dflt", p0, 8'hA5, 1'b0, 1'b0);
    expect_quiet("dflt");

    send_frame(8'hA5, 1'b1, 1'b1, -1, -1, p0);
    hold(1'b1, OS);
    expect_word("perr", p0, 8'hA5, 1'b1, 1'b0);
    send_frame(8'h01, 1'b1, 1'b1, -1, -1, p0);
    hold(1'b1, OS);
    expect_word("pok", p0, 8'h01, 1'b0, 1'b0);

    send_frame(8'h3C, 1'b0, 1'b0, -1, -1, p0);
    hold(1'b0, 3 * OS);
    expect_word("brk", p0, 8'h3C, 1'b0, 1'b1);
    hold(1'b1, 3 * OS);
    expect_quiet("brk");

    hold(1'b0, 4);
    hold(1'b1, 2 * OS);
    expect_quiet("fstart");
    send_frame(8'h5A, 1'b0, 1'b1, -1, -1, p0);
    hold(1'b1, OS);
    expect_word("afterfs", p0, 8'h5A, 1'b0, 1'b0);

    send_frame(8'h00, 1'b0, 1'b1, -1, -1, p0);
    send_frame(8'hFF, 1'b0, 1'b1, -1, -1, p1);
    hold(1'b1, OS);
    expect_word("b2b0", p0, 8'h00, 1'b0, 1'b0);
    expect_word("b2b1", p1, 8'hFF, 1'b0, 1'b0);
    check("b2b_gap", 32'(p1 - p0), 32'(11 * OS));

    send_frame(8'hF8, 1'b1, 1'b1, -1, 4, p0);
    hold(1'b1, 2 * OS);
    expect_quiet("rstmid");
    send_frame(8'h81, 1'b0, 1'b1, -1, -1, p0);
    hold(1'b1, OS);
    expect_word("afterrst", p0, 8'h81, 1'b0, 1'b0);

`ifdef UART_RX_MAJORITY_EN
    gw = 8'h00;
`else
    gw = 8'h08;
`endif
    send_frame(8'h00, 1'b0, 1'b1, 3, -1, p0);
    hold(1'b1, OS);
    expect_word("glitch", p0, gw, ^gw, 1'b0);

    for (int i = 0; i < 8; i++) begin
      d    = 8'($urandom);
      pbit = 1'($urandom_range(0, 1));
      sbit = ($urandom_range(0, 3) != 0);
      send_frame(d, pbit, sbit, -1, -1, p0);
      hold(1'b1, $urandom_range(1, 2 * OS));
      expect_word("rnd", p0, d, (pbit != (^d)), ~sbit);
    end
    hold(1'b1, 2 * OS);
    expect_quiet("end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
